// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter that drives the sel/en pair of a mux_2to1
// datapath and steers the granted requester onto one shared valid/ready channel.
module mux2_rr_arbiter #(
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid0,
  input  logic [W-1:0] req_data0,
  output logic         req_ready0,
  input  logic         req_valid1,
  input  logic [W-1:0] req_data1,
  output logic         req_ready1,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         sel,
  output logic         en,
  output logic         busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             sel_q, sel_d;

  logic granted;
  logic owner;
  logic cur_valid;
  logic oth_valid;
  logic beat;
  logic release_grant;

  // Gating with rst keeps a beat from being accepted in the cycle that aborts a grant.
  assign granted   = (state_q != IDLE) && !rst;
  assign owner     = (state_q == GRANT1);
  assign cur_valid = owner ? req_valid1 : req_valid0;
  assign oth_valid = owner ? req_valid0 : req_valid1;
  assign beat      = granted && cur_valid && out_ready;
  assign release_grant = !cur_valid || (beat && (beat_cnt_q == LAST_BEAT));

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
      sel_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      sel_q        <= sel_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid0 && req_valid1) begin
          state_d = last_grant_q ? GRANT0 : GRANT1;
        end else if (req_valid0) begin
          state_d = GRANT0;
        end else if (req_valid1) begin
          state_d = GRANT1;
        end
      end
      GRANT0, GRANT1: begin
        if (release_grant) begin
          last_grant_d = owner;
          beat_cnt_d   = '0;
          if (oth_valid) begin
            state_d = owner ? GRANT0 : GRANT1;
          end else if (cur_valid) begin
            state_d = state_q;
          end else begin
            state_d = IDLE;
          end
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // sel follows the grant and otherwise keeps its last registered value.
  always_comb begin
    sel_d = sel_q;
    if (state_d == GRANT0) sel_d = 1'b0;
    if (state_d == GRANT1) sel_d = 1'b1;
  end

  always_comb begin
    en         = granted;
    busy       = granted;
    sel        = sel_q;
    out_valid  = 1'b0;
    out_data   = '0;
    req_ready0 = 1'b0;
    req_ready1 = 1'b0;
    if (granted) begin
      out_valid  = cur_valid;
      out_data   = owner ? req_data1 : req_data0;
      req_ready0 = !owner && out_ready;
      req_ready1 = owner && out_ready;
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard bench for mux2_rr_arbiter: a cycle-level reference of the arbitration
// rules feeds expected control and beat queues that an independent monitor drains.
module tb_mux2_rr_arbiter;

  localparam int W         = 8;
  localparam int MAX_BURST = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid0, req_valid1;
  logic [W-1:0] req_data0, req_data1;
  logic         req_ready0, req_ready1;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         sel, en, busy;

  mux2_rr_arbiter #(.W(W), .MAX_BURST(MAX_BURST)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid0 (req_valid0),
    .req_data0  (req_data0),
    .req_ready0 (req_ready0),
    .req_valid1 (req_valid1),
    .req_data1  (req_data1),
    .req_ready1 (req_ready1),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .sel        (sel),
    .en         (en),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         en, sel, busy, ov, r0, r1;
    logic [W-1:0] od;
  } ctrl_t;

  typedef struct {
    logic         src;
    logic [W-1:0] data;
  } beat_t;

  ctrl_t ctrl_q[$];
  beat_t beat_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every cycle's control outputs and every accepted beat.
  always begin
    ctrl_t c;
    beat_t b;
    @(negedge clk);
    if (ctrl_q.size() > 0) begin
      c = ctrl_q.pop_front();
      check("en",         en,         c.en);
      check("sel",        sel,        c.sel);
      check("busy",       busy,       c.busy);
      check("out_valid",  out_valid,  c.ov);
      check("req_ready0", req_ready0, c.r0);
      check("req_ready1", req_ready1, c.r1);
      check("out_data",   out_data,   c.od);
      if (out_valid && out_ready) begin
        check("beat_expected", beat_q.size() != 0, 1);
        if (beat_q.size() != 0) begin
          b = beat_q.pop_front();
          check("beat_data", out_data, b.data);
          check("beat_src",  sel,      b.src);
        end
      end
    end
  end

  // Reference model: who owns the channel, beats taken in this burst, last winner.
  int   m_owner = -1;
  int   m_cnt   = 0;
  int   m_last  = 1;
  logic m_sel   = 1'b0;

  logic [W-1:0] src0[$];
  logic [W-1:0] src1[$];
  bit   vflag[2];
  bit   eager = 1'b1;
  logic ordy  = 1'b1;
  logic [W-1:0] seq = 8'h40;

  task automatic step(input logic r);
    ctrl_t c;
    beat_t b;
    logic v[2];
    logic [W-1:0] d[2];
    bit acc;
    int x;

    for (int i = 0; i < 2; i++) begin
      if (eager) vflag[i] = 1'b1;
      else if (!vflag[i]) vflag[i] = ($urandom_range(0, 2) == 0);
    end
    v[0] = vflag[0] && (src0.size() > 0);
    v[1] = vflag[1] && (src1.size() > 0);
    d[0] = v[0] ? src0[0] : W'($urandom);
    d[1] = v[1] ? src1[0] : W'($urandom);

    rst        = r;
    req_valid0 = v[0];
    req_data0  = d[0];
    req_valid1 = v[1];
    req_data1  = d[1];
    out_ready  = ordy;

    c = '{en: 0, sel: m_sel, busy: 0, ov: 0, r0: 0, r1: 0, od: '0};
    acc = 1'b0;
    if (r) begin
      m_owner = -1;
      m_cnt   = 0;
      m_last  = 1;
      m_sel   = 1'b0;
    end else begin
      if (m_owner >= 0) begin
        x      = m_owner;
        c.en   = 1'b1;
        c.busy = 1'b1;
        c.sel  = x[0];
        c.ov   = v[x];
        c.od   = d[x];
        c.r0   = (x == 0) && ordy;
        c.r1   = (x == 1) && ordy;
        acc    = v[x] && ordy;
        if (acc) begin
          b = '{src: x[0], data: d[x]};
          beat_q.push_back(b);
          if (x == 0) void'(src0.pop_front());
          else        void'(src1.pop_front());
          if (!eager) vflag[x] = ($urandom_range(0, 3) != 0);
        end
        if (!v[x] || (acc && m_cnt == MAX_BURST - 1)) begin
          m_last = x;
          m_cnt  = 0;
          if (v[1-x])  m_owner = 1 - x;
          else if (!v[x]) m_owner = -1;
        end else if (acc) begin
          m_cnt++;
        end
      end else begin
        if (v[0] && v[1]) m_owner = 1 - m_last;
        else if (v[0])    m_owner = 0;
        else if (v[1])    m_owner = 1;
      end
      if (m_owner >= 0) m_sel = m_owner[0];
    end
    ctrl_q.push_back(c);

    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;
    req_data0  = '0;
    req_data1  = '0;
    out_ready  = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with both requesting, then the first grant goes to requester 0.
    src0.push_back(8'hA0);
    src1.push_back(8'hB0);
    step(1'b1);
    step(1'b1);
    run(6);

    // Single requester hitting the burst cap re-enters its grant without a bubble.
    for (int i = 0; i < 6; i++) src0.push_back(W'(8'h11 + i));
    run(10);

    // Continuous contention: bursts of MAX_BURST alternate with no idle cycle.
    for (int i = 0; i < 12; i++) begin
      src0.push_back(W'(8'h20 + i));
      src1.push_back(W'(8'h60 + i));
    end
    run(30);

    // Backpressure during GRANT1 holds the grant and accepts nothing.
    for (int i = 0; i < 3; i++) src1.push_back(W'(8'hC0 + i));
    ordy = 1'b0;
    run(7);
    ordy = 1'b1;
    run(6);

    // Requester 0 drops valid after two beats while requester 1 waits.
    src0.push_back(8'h31);
    src0.push_back(8'h32);
    for (int i = 0; i < 3; i++) src1.push_back(W'(8'h71 + i));
    run(10);

    // Reset mid-burst in GRANT1, then both contend and requester 0 wins.
    for (int i = 0; i < 6; i++) src1.push_back(W'(8'hD0 + i));
    run(3);
    step(1'b1);
    for (int i = 0; i < 3; i++) src0.push_back(W'(8'hE0 + i));
    run(20);
    src1.delete();
    run(4);

    // Randomised traffic, gaps, backpressure and occasional resets.
    eager = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (src0.size() < 3 && $urandom_range(0, 3) == 0) begin
        src0.push_back(seq);
        seq++;
      end
      if (src1.size() < 3 && $urandom_range(0, 3) == 0) begin
        src1.push_back(seq);
        seq++;
      end
      ordy = ($urandom_range(0, 4) != 0);
      step($urandom_range(0, 299) == 0);
    end

    @(negedge clk);
    #1;
    check("beat_queue_drained", beat_q.size(), 0);
    check("ctrl_queue_drained", ctrl_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
